// File: rtl/aes_pkg.sv
// AES shared package: block width, inverse S-box and the inverse-cipher
// byte/column transforms. The encrypt core also imports this package.
// State layout: byte i (FIPS s[i%4, i/4]) sits at [127-8*i -: 8].
package aes_pkg;

  localparam int BLOCK_W = 128;

  // Entry x is at index x; the first byte of the concatenation is index 0.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a small constant (only 9/11/13/14 are needed here).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] acc;
    logic [7:0] pow;
    acc = 8'h00;
    pow = a;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) acc = acc ^ pow;
      pow = xtime(pow);
    end
    return acc;
  endfunction

  // Row r rotates right by r bytes: out[r,c] = in[r,(c-r) mod 4].
  function automatic logic [BLOCK_W-1:0] inv_shift_rows(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] res;
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return res;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_sub_bytes(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] res;
    res = '0;
    for (int i = 0; i < 16; i++)
      res[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
    return res;
  endfunction

  // Each column times the circulant matrix {0e,0b,0d,09}.
  function automatic logic [BLOCK_W-1:0] inv_mix_columns(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] res;
    logic [7:0] a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      res[127-8*(4*c)   -: 8] = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
      res[127-8*(4*c+1) -: 8] = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
      res[127-8*(4*c+2) -: 8] = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
      res[127-8*(4*c+3) -: 8] = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse-cipher round.
// Ports:
//   stateIn   - current 128-bit state
//   roundKey  - round key for this round
//   lastRound - high on the final round, which skips InvMixColumns
//   stateOut  - next state
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] stateIn,
  input  logic [BLOCK_W-1:0] roundKey,
  input  logic               lastRound,
  output logic [BLOCK_W-1:0] stateOut
);

  logic [BLOCK_W-1:0] keyed;

  always_comb begin
    keyed    = inv_sub_bytes(inv_shift_rows(stateIn)) ^ roundKey;
    stateOut = lastRound ? keyed : inv_mix_columns(keyed);
  end

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES inverse cipher, one round per enabled clock.
// Ports:
//   clk     - clock
//   reset   - synchronous active-high, clears state, round counter and done
//   in      - ciphertext, sampled only on the first enabled step
//   allKeys - expanded key schedule, round key 0 in the MSBs
//   enable  - advance one step per clock while high, hold otherwise
//   out     - state register (plaintext once done)
//   done    - high after the final round
module aes_decrypt
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BLOCK_W-1:0]       in,
  input  logic [128*(Nr+1)-1:0]    allKeys,
  input  logic                     enable,
  output logic [BLOCK_W-1:0]       out,
  output logic                     done
);

  localparam int RW = $clog2(Nr + 2);
  localparam logic [RW-1:0] LAST_ROUND = RW'(Nr);

  // Key length and round count must describe the same AES variant.
  if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : gBadParams
    $error("aes_decrypt: unsupported Nk/Nr combination");
  end

  logic [BLOCK_W-1:0] stateReg, stateNext;
  logic [RW-1:0]      roundReg, roundNext;
  logic               doneReg, doneNext;
  logic [RW-1:0]      keyIdx;
  logic [BLOCK_W-1:0] roundKey;
  logic [BLOCK_W-1:0] roundOut;
  logic               lastRound;
  logic [BLOCK_W-1:0] roundKeys [0:Nr];

  genvar gi;
  generate
    for (gi = 0; gi <= Nr; gi++) begin : gKeys
      assign roundKeys[gi] = allKeys[128*(Nr+1)-1-128*gi -: 128];
    end
  endgenerate

  // Step r uses rk[Nr-r]; this covers both the initial whitening (r=0)
  // and the final round (r=Nr). Once saturated the key is unused.
  always_comb begin
    keyIdx    = (roundReg <= LAST_ROUND) ? (LAST_ROUND - roundReg) : '0;
    roundKey  = roundKeys[keyIdx];
    lastRound = (roundReg == LAST_ROUND);
  end

  aes_inv_round uRound (
    .stateIn  (stateReg),
    .roundKey (roundKey),
    .lastRound(lastRound),
    .stateOut (roundOut)
  );

  always_comb begin
    stateNext = stateReg;
    roundNext = roundReg;
    doneNext  = doneReg;
    if (enable && (roundReg <= LAST_ROUND)) begin
      roundNext = roundReg + RW'(1);
      stateNext = (roundReg == '0) ? (in ^ roundKey) : roundOut;
      if (lastRound) doneNext = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= '0;
      roundReg <= '0;
      doneReg  <= 1'b0;
    end else begin
      stateReg <= stateNext;
      roundReg <= roundNext;
      doneReg  <= doneNext;
    end
  end

  assign out  = stateReg;
  assign done = doneReg;

endmodule

// File: tb/tb_aes_decrypt.sv
// Bench for aes_decrypt: AES-128/192/256 instances side by side, driven by
// the same reset/enable. A forward-cipher model builds the key schedules and
// the expected state after every step; one expected entry per instance is
// queued each cycle and compared after the clock edge.
module tb_aes_decrypt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable;
  logic [127:0]  in128, in192, in256;
  logic [127:0]  out128, out192, out256;
  logic          done128, done192, done256;
  logic [1407:0] keys128;
  logic [1663:0] keys192;
  logic [1919:0] keys256;

  aes_decrypt #(.Nk(4), .Nr(10)) dut128 (.clk(clk), .reset(reset), .in(in128), .allKeys(keys128),
                                         .enable(enable), .out(out128), .done(done128));
  aes_decrypt #(.Nk(6), .Nr(12)) dut192 (.clk(clk), .reset(reset), .in(in192), .allKeys(keys192),
                                         .enable(enable), .out(out192), .done(done192));
  aes_decrypt #(.Nk(8), .Nr(14)) dut256 (.clk(clk), .reset(reset), .in(in256), .allKeys(keys256),
                                         .enable(enable), .out(out256), .done(done256));

  localparam logic [127:0] PLAIN = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  int checks = 0;
  int errors = 0;

  task automatic checkValue(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sbox [256];
  logic [127:0] expTab [3][16];  // expected out after k enabled steps
  int           nrOf [3] = '{10, 12, 14};
  int           mk [3];          // model step count per instance
  int           cycNum = 0;

  typedef struct {
    int           dut;
    logic [127:0] expOut;
    logic         expDone;
  } sbEntry_t;
  sbEntry_t sbQueue[$];

  function automatic logic [7:0] gmul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expandKey(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] res;
    int            total;
    total = 4 * (nk + 7);
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul8(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    res = '0;
    for (int i = 0; i < total; i++) res[1919-32*i -: 32] = w[i];
    return res;
  endfunction

  // Forward SubBytes + ShiftRows, plus MixColumns when mix is set.
  function automatic logic [127:0] fwdRound(input logic [127:0] s, input bit mix);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r+4*c] = a[r+4*((c+r)%4)];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul8(a0, 8'h02) ^ gmul8(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul8(a1, 8'h02) ^ gmul8(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul8(a2, 8'h02) ^ gmul8(a3, 8'h03);
        t[4*c+3] = gmul8(a0, 8'h03) ^ a1 ^ a2 ^ gmul8(a3, 8'h02);
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res;
  endfunction

  // The inverse cipher after k steps (1..Nr) holds SR(SB(s[Nr-k])), where
  // s[i] is the forward cipher state after AddRoundKey of round i.
  task automatic buildModel();
    logic [7:0]    inv;
    logic [1919:0] sched;
    logic [127:0]  st [15];
    logic [255:0]  key;
    int            nr;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul8(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int d = 0; d < 3; d++) begin
      nr  = nrOf[d];
      key = '0;
      for (int b = 0; b < 4 * (nr - 6); b++) key[255-8*b -: 8] = 8'(b);
      sched = expandKey(key, nr - 6);
      case (d)
        0:       keys128 = sched[1919 -: 1408];
        1:       keys192 = sched[1919 -: 1664];
        default: keys256 = sched;
      endcase
      st[0] = PLAIN ^ sched[1919 -: 128];
      for (int i = 1; i < nr; i++) st[i] = fwdRound(st[i-1], 1'b1) ^ sched[1919-128*i -: 128];
      for (int k = 0; k < 16; k++) expTab[d][k] = '0;
      for (int k = 1; k <= nr; k++) expTab[d][k] = fwdRound(st[nr-k], 1'b0);
      expTab[d][nr+1] = PLAIN;
    end
  endtask

  // One clock: queue expectations for this edge, clock, then compare.
  task automatic cycle(input bit rst, input bit en);
    sbEntry_t e;
    reset  = rst;
    enable = en;
    for (int d = 0; d < 3; d++) begin
      if (rst) mk[d] = 0;
      else if (en && mk[d] <= nrOf[d]) mk[d]++;
      e.dut     = d;
      e.expOut  = expTab[d][mk[d]];
      e.expDone = (mk[d] == nrOf[d] + 1);
      sbQueue.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cycNum++;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      case (e.dut)
        0: begin
          checkValue($sformatf("aes128 c%0d out", cycNum), out128, e.expOut);
          checkValue($sformatf("aes128 c%0d done", cycNum), {127'b0, done128}, {127'b0, e.expDone});
        end
        1: begin
          checkValue($sformatf("aes192 c%0d out", cycNum), out192, e.expOut);
          checkValue($sformatf("aes192 c%0d done", cycNum), {127'b0, done192}, {127'b0, e.expDone});
        end
        default: begin
          checkValue($sformatf("aes256 c%0d out", cycNum), out256, e.expOut);
          checkValue($sformatf("aes256 c%0d done", cycNum), {127'b0, done256}, {127'b0, e.expDone});
        end
      endcase
    end
    $display("cycle %0d rst=%0b en=%0b out128=%h done=%0b%0b%0b", cycNum, rst, en, out128,
             done128, done192, done256);
  endtask

  task automatic loadCiphertexts();
    in128 = CT128;
    in192 = CT192;
    in256 = CT256;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    loadCiphertexts();
    buildModel();

    // Reset with enable high: out and done cleared.
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);

    // Full runs; in is scrambled after the first step and must be ignored.
    cycle(1'b0, 1'b1);
    in128 = {$urandom, $urandom, $urandom, $urandom};
    in192 = {$urandom, $urandom, $urandom, $urandom};
    in256 = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b1);

    // Hold after done with in zeroed: no restart.
    in128 = '0; in192 = '0; in256 = '0;
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);

    // Pause after four steps.
    loadCiphertexts();
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);

    // Reset mid-operation at r=6, then a full rerun.
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
